// File: rtl/scan_loader_if.sv
// Byte command/readback bundle between a programming host and scan_loader.
// The master sends command bytes and sees the captured readback bytes.
interface scan_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/scan_loader.sv
// Serializes command bytes MSB-first onto the memory bank scan chain while
// capturing scan_out into readback bytes; the CPU is held for the whole session.
module scan_loader #(
    parameter int CHAIN_LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    scan_loader_if.slave   bus,
    input  logic           abort,
    output logic           scan_enable,
    output logic           scan_in,
    input  logic           scan_out,
    output logic           cpu_halt,
    output logic           done
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r,       state_s;
    logic [CNT_W-1:0] byte_cnt_r,    byte_cnt_s;
    logic [2:0]       bit_cnt_r,     bit_cnt_s;
    logic [7:0]       shreg_r,       shreg_s;
    logic [7:0]       cap_r,         cap_s;
    logic             cmd_ready_r,   cmd_ready_s;
    logic             scan_enable_r, scan_enable_s;
    logic             scan_in_r,     scan_in_s;
    logic             rd_valid_r,    rd_valid_s;
    logic [7:0]       rd_data_r,     rd_data_s;
    logic             cpu_halt_r,    cpu_halt_s;
    logic             done_r,        done_s;
    logic             accept_s;

    assign accept_s = bus.cmd_valid & cmd_ready_r;

    // Next-state and next-output decode; pulse outputs and scan_enable default low.
    always_comb begin
        state_s       = state_r;
        byte_cnt_s    = byte_cnt_r;
        bit_cnt_s     = bit_cnt_r;
        shreg_s       = shreg_r;
        cap_s         = cap_r;
        cmd_ready_s   = cmd_ready_r;
        scan_enable_s = 1'b0;
        scan_in_s     = 1'b0;
        rd_valid_s    = 1'b0;
        rd_data_s     = rd_data_r;
        cpu_halt_s    = cpu_halt_r;
        done_s        = 1'b0;

        if (abort && (state_r != ST_IDLE)) begin
            // A half-shifted chain is deliberately left where it stopped.
            state_s     = ST_IDLE;
            byte_cnt_s  = '0;
            bit_cnt_s   = 3'd0;
            cmd_ready_s = 1'b1;
            cpu_halt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WAIT: begin
                    if (accept_s) begin
                        state_s       = ST_SHIFT;
                        shreg_s       = bus.cmd_data;
                        scan_in_s     = bus.cmd_data[7];
                        scan_enable_s = 1'b1;
                        bit_cnt_s     = 3'd0;
                        cmd_ready_s   = 1'b0;
                        cpu_halt_s    = 1'b1;
                    end else begin
                        cmd_ready_s   = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cap_s = {cap_r[6:0], scan_out};
                    if (bit_cnt_r == 3'd7) begin
                        rd_data_s  = {cap_r[6:0], scan_out};
                        rd_valid_s = 1'b1;
                        byte_cnt_s = byte_cnt_r + ONE_CNT;
                        bit_cnt_s  = 3'd0;
                        if (byte_cnt_r == LAST_CNT) begin
                            state_s     = ST_DONE;
                            done_s      = 1'b1;
                            cmd_ready_s = 1'b0;
                        end else begin
                            state_s     = ST_WAIT;
                            cmd_ready_s = 1'b1;
                        end
                    end else begin
                        // shreg_r[6] is the bit that follows the one now on scan_in.
                        bit_cnt_s     = bit_cnt_r + 3'd1;
                        shreg_s       = {shreg_r[6:0], 1'b0};
                        scan_in_s     = shreg_r[6];
                        scan_enable_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_s     = ST_IDLE;
                    byte_cnt_s  = '0;
                    cpu_halt_s  = 1'b0;
                    cmd_ready_s = 1'b1;
                end
                default: begin
                    state_s     = ST_IDLE;
                    byte_cnt_s  = '0;
                    bit_cnt_s   = 3'd0;
                    cmd_ready_s = 1'b1;
                    cpu_halt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset drops scan_enable immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= '0;
            bit_cnt_r     <= 3'd0;
            shreg_r       <= 8'h00;
            cap_r         <= 8'h00;
            cmd_ready_r   <= 1'b1;
            scan_enable_r <= 1'b0;
            scan_in_r     <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_data_r     <= 8'h00;
            cpu_halt_r    <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            byte_cnt_r    <= byte_cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            shreg_r       <= shreg_s;
            cap_r         <= cap_s;
            cmd_ready_r   <= cmd_ready_s;
            scan_enable_r <= scan_enable_s;
            scan_in_r     <= scan_in_s;
            rd_valid_r    <= rd_valid_s;
            rd_data_r     <= rd_data_s;
            cpu_halt_r    <= cpu_halt_s;
            done_r        <= done_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
    assign scan_enable   = scan_enable_r;
    assign scan_in       = scan_in_r;
    assign cpu_halt      = cpu_halt_r;
    assign done          = done_r;

endmodule

// File: tb/tb_scan_loader.sv
// Scoreboard bench for scan_loader: a bit-queue model of the scan chain predicts
// each readback byte; a monitor compares them as rd_valid and done appear.
module tb_scan_loader;

    localparam int L      = 256;
    localparam int NBYTES = L / 8;

    logic clk;
    logic rst;
    logic abort;
    logic scan_enable;
    logic scan_in;
    logic scan_out;
    logic cpu_halt;
    logic done;

    scan_loader_if bus ();

    scan_loader #(.CHAIN_LEN(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .abort       (abort),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .cpu_halt    (cpu_halt),
        .done        (done)
    );

    // Memory bank stand-in: a plain shift register, not reset by the loader reset.
    logic [L-1:0] env_chain;
    assign scan_out = env_chain[L-1];
    always @(posedge clk) begin
        if (scan_enable) env_chain <= {env_chain[L-2:0], scan_in};
    end

    always #5 clk = ~clk;

    // Reference: ref_q[0] is the bit currently presented at scan_out.
    bit         ref_q[$];
    logic [7:0] exp_q[$];
    int         sent_cnt;
    int         done_cnt;
    int         n_vec;
    int         n_err;
    logic [7:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_accept(input logic [7:0] b, input int nbits);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = ref_q[i];
        exp_q.push_back(e);
        for (int i = 0; i < nbits; i++) begin
            void'(ref_q.pop_front());
            ref_q.push_back(b[7-i]);
        end
        sent_cnt++;
    endfunction

    // Enter at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int nbits);
        int t;
        t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (!bus.cmd_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(b, nbits);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic chk_chain();
        int bad;
        bad = 0;
        for (int i = 0; i < L; i++) if (ref_q[i] !== env_chain[L-1-i]) bad++;
        chk("chain_image", 32'(bad), 32'd0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("halt_in_done", 32'(cpu_halt), 32'd1);
        @(negedge clk);
        chk("halt_after_done", 32'(cpu_halt), 32'd0);
        chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);
        chk_chain();
    endtask

    task automatic run_session(input int rnd, input int gap);
        logic [7:0] b;
        for (int i = 0; i < NBYTES; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            send_byte(b, 8);
            if (gap && i < NBYTES - 1) begin
                repeat (9) @(negedge clk);
                chk("wait_scan_en", 32'(scan_enable), 32'd0);
                chk("wait_halt", 32'(cpu_halt), 32'd1);
                chk("wait_ready", 32'(bus.cmd_ready), 32'd1);
                repeat (4) @(negedge clk);
            end
        end
        wait_done();
    endtask

    // Monitor: scoreboard pops on every readback byte and checks each done pulse.
    always @(negedge clk) begin
        if (rst && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(mon_e));
            end
        end
        if (rst && done) begin
            chk("done_byte_count", 32'(sent_cnt), 32'(NBYTES));
            sent_cnt = 0;
            done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        clk = 1'b0;
        rst = 1'b0;
        abort = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = 8'h00;
        n_vec = 0;
        n_err = 0;
        sent_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < L; i++) env_chain[i] = 1'($urandom);
        for (int i = 0; i < L; i++) ref_q.push_back(env_chain[L-1-i]);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_scan_en", 32'(scan_enable), 32'd0);
        chk("rst_halt", 32'(cpu_halt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_abort_halt", 32'(cpu_halt), 32'd0);

        // Single 0xA5: bit order, enable window, halt and readback latency.
        send_byte(8'hA5, 8);
        chk("a5_halt", 32'(cpu_halt), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("a5_scan_en", 32'(scan_enable), 32'd1);
            chk("a5_scan_in", 32'(scan_in), 32'((8'hA5 >> (7 - k)) & 8'h01));
            chk("a5_no_rd_early", 32'(bus.rd_valid), 32'd0);
            @(negedge clk);
        end
        chk("a5_rd_valid_9th", 32'(bus.rd_valid), 32'd1);
        chk("a5_scan_en_off", 32'(scan_enable), 32'd0);
        @(negedge clk);
        chk("a5_rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
        chk("a5_wait_ready", 32'(bus.cmd_ready), 32'd1);
        chk("a5_wait_halt", 32'(cpu_halt), 32'd1);
        for (int i = 1; i < NBYTES; i++) send_byte(8'($urandom), 8);
        wait_done();

        // Two identical counting sessions; the second reads back 0x00..0x1F.
        run_session(0, 0);
        run_session(0, 0);
        run_session(1, 1);

        // Abort during shift cycle 4 of byte 10: five bits reach the chain.
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 8);
        send_byte(8'($urandom), 5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        sent_cnt = 0;
        chk("abort_halt", 32'(cpu_halt), 32'd0);
        chk("abort_scan_en", 32'(scan_enable), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done_pulse", 32'(done_cnt), 32'(d0));
        run_session(1, 0);

        // Abort together with a handshake in WAIT: the byte is dropped.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 8);
        repeat (8) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = 8'h3C;
        abort = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        abort = 1'b0;
        sent_cnt = 0;
        chk("abort_hs_halt", 32'(cpu_halt), 32'd0);
        chk("abort_hs_scan_en", 32'(scan_enable), 32'd0);
        @(negedge clk);
        chk("abort_hs_no_shift", 32'(scan_enable), 32'd0);
        chk_chain();

        // Asynchronous reset three edges into a byte.
        for (int i = 0; i < 2; i++) send_byte(8'($urandom), 8);
        send_byte(8'($urandom), 3);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("areset_scan_en", 32'(scan_enable), 32'd0);
        chk("areset_halt", 32'(cpu_halt), 32'd0);
        chk("areset_ready", 32'(bus.cmd_ready), 32'd1);
        void'(exp_q.pop_back());
        sent_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_chain();
        run_session(1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
